// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline MEM stage: EX/MEM register, branch resolve, data memory, MEM/WB register
//
// Purpose
//   Registers the EX results (EX/MEM), resolves the branch from the registered
//   ALU flags, performs little-endian word/half/byte loads and stores against
//   an internal MEM_WORDS x 32 data memory, and registers the load data and
//   writeback controls (MEM/WB).
//
// Ports
//   Clk, Reset                 clock, synchronous active-high reset
//   ALUResult, WriteData       EX result / byte address, store data
//   AddResult                  EX branch target
//   Zero, SignBit              EX ALU flags
//   RegDstAddress              destination register
//   Branch, RegWrite, MemWrite, MemRead, MemToReg   EX control bits
//   BitSel                     access size: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned
//   BranchLogicOp              branch condition select
//   Flush                      EX/MEM captures a bubble
//   PCSrc, BranchTarget        branch taken, registered branch target
//   MemReadData_W, ALUResult_W, RegDstAddress_W, RegWrite_W, MemToReg_W   MEM/WB outputs

module memory_stage #(
  parameter int MEM_WORDS = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [31:0] AddResult,
  input  logic        Zero,
  input  logic        SignBit,
  input  logic [4:0]  RegDstAddress,
  input  logic        Branch,
  input  logic        RegWrite,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic        MemToReg,
  input  logic [1:0]  BitSel,
  input  logic [2:0]  BranchLogicOp,
  input  logic        Flush,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic [31:0] MemReadData_W,
  output logic [31:0] ALUResult_W,
  output logic [4:0]  RegDstAddress_W,
  output logic        RegWrite_W,
  output logic        MemToReg_W
);

  localparam int AW = $clog2(MEM_WORDS);

  // EX/MEM register
  logic [31:0] ALUResult_M;
  logic [31:0] WriteData_M;
  logic [31:0] AddResult_M;
  logic        Zero_M;
  logic        SignBit_M;
  logic [4:0]  RegDstAddress_M;
  logic        Branch_M;
  logic        RegWrite_M;
  logic        MemWrite_M;
  logic        MemRead_M;
  logic        MemToReg_M;
  logic [1:0]  BitSel_M;
  logic [2:0]  BranchLogicOp_M;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ALUResult_M     <= '0;
      WriteData_M     <= '0;
      AddResult_M     <= '0;
      Zero_M          <= 1'b0;
      SignBit_M       <= 1'b0;
      RegDstAddress_M <= '0;
      Branch_M        <= 1'b0;
      RegWrite_M      <= 1'b0;
      MemWrite_M      <= 1'b0;
      MemRead_M       <= 1'b0;
      MemToReg_M      <= 1'b0;
      BitSel_M        <= '0;
      BranchLogicOp_M <= '0;
    end else begin
      // Data fields are captured even on a flush; only the controls are killed.
      ALUResult_M     <= ALUResult;
      WriteData_M     <= WriteData;
      AddResult_M     <= AddResult;
      Zero_M          <= Zero;
      SignBit_M       <= SignBit;
      RegDstAddress_M <= RegDstAddress;
      BitSel_M        <= BitSel;
      BranchLogicOp_M <= BranchLogicOp;
      Branch_M        <= Branch   & ~Flush;
      RegWrite_M      <= RegWrite & ~Flush;
      MemWrite_M      <= MemWrite & ~Flush;
      MemRead_M       <= MemRead  & ~Flush;
      MemToReg_M      <= MemToReg & ~Flush;
    end
  end

  // Branch resolution
  logic branch_cond;

  always_comb begin
    branch_cond = 1'b0;
    case (BranchLogicOp_M)
      3'b000:  branch_cond = Zero_M;
      3'b001:  branch_cond = ~Zero_M;
      3'b010:  branch_cond = ~SignBit_M;
      3'b011:  branch_cond = ~SignBit_M & ~Zero_M;
      3'b100:  branch_cond = SignBit_M | Zero_M;
      3'b101:  branch_cond = SignBit_M;
      default: branch_cond = 1'b0;
    endcase
  end

  assign PCSrc        = Branch_M & branch_cond;
  assign BranchTarget = AddResult_M;

  // Data memory. Upper address bits are dropped so accesses wrap.
  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] word_addr;
  logic [31:0]   rd_word;
  logic [15:0]   rd_half;
  logic [7:0]    rd_byte;
  logic [31:0]   load_data;

  assign word_addr = ALUResult_M[AW+1:2];
  assign rd_word   = mem[word_addr];
  assign rd_half   = ALUResult_M[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (ALUResult_M[1:0])
      2'b00: rd_byte = rd_word[7:0];
      2'b01: rd_byte = rd_word[15:8];
      2'b10: rd_byte = rd_word[23:16];
      2'b11: rd_byte = rd_word[31:24];
    endcase
  end

  always_comb begin
    load_data = rd_word;
    case (BitSel_M)
      2'b00: load_data = rd_word;
      2'b01: load_data = {{16{rd_half[15]}}, rd_half};
      2'b10: load_data = {{24{rd_byte[7]}}, rd_byte};
      2'b11: load_data = {24'h000000, rd_byte};
    endcase
  end

  // Store merge: replicate the store data across lanes, then enable only the
  // lanes the access size and low address bits select.
  logic [3:0]  lane_en;
  logic [31:0] wr_lanes;
  logic [31:0] wr_word;

  always_comb begin
    lane_en  = 4'b1111;
    wr_lanes = WriteData_M;
    case (BitSel_M)
      2'b00: begin
        lane_en  = 4'b1111;
        wr_lanes = WriteData_M;
      end
      2'b01: begin
        lane_en  = ALUResult_M[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{WriteData_M[15:0]}};
      end
      default: begin
        lane_en  = 4'b0001 << ALUResult_M[1:0];
        wr_lanes = {4{WriteData_M[7:0]}};
      end
    endcase
    wr_word = rd_word;
    for (int l = 0; l < 4; l++) begin
      if (lane_en[l]) wr_word[8*l +: 8] = wr_lanes[8*l +: 8];
    end
  end

  // Reset has priority so a store sitting in EX/MEM is dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (MemWrite_M) begin
      mem[word_addr] <= wr_word;
    end
  end

  // MEM/WB register. load_data is sampled before this edge's store lands,
  // so a combined read+write returns the old contents.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      MemReadData_W   <= '0;
      ALUResult_W     <= '0;
      RegDstAddress_W <= '0;
      RegWrite_W      <= 1'b0;
      MemToReg_W      <= 1'b0;
    end else begin
      MemReadData_W   <= MemRead_M ? load_data : 32'h0;
      ALUResult_W     <= ALUResult_M;
      RegDstAddress_W <= RegDstAddress_M;
      RegWrite_W      <= RegWrite_M;
      MemToReg_W      <= MemToReg_M;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage

module tb_memory_stage;

  localparam int MEM_WORDS = 256;
  localparam int MEM_BYTES = MEM_WORDS * 4;
  localparam int N_RAND    = 160;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] ALUResult, WriteData, AddResult;
  logic        Zero, SignBit;
  logic [4:0]  RegDstAddress;
  logic        Branch, RegWrite, MemWrite, MemRead, MemToReg;
  logic [1:0]  BitSel;
  logic [2:0]  BranchLogicOp;
  logic        Flush;
  logic        PCSrc;
  logic [31:0] BranchTarget, MemReadData_W, ALUResult_W;
  logic [4:0]  RegDstAddress_W;
  logic        RegWrite_W, MemToReg_W;

  int total = 0;
  int bad   = 0;

  memory_stage #(.MEM_WORDS(MEM_WORDS)) dut (
    .Clk(Clk), .Reset(Reset), .ALUResult(ALUResult), .WriteData(WriteData),
    .AddResult(AddResult), .Zero(Zero), .SignBit(SignBit),
    .RegDstAddress(RegDstAddress), .Branch(Branch), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg),
    .BitSel(BitSel), .BranchLogicOp(BranchLogicOp), .Flush(Flush),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget), .MemReadData_W(MemReadData_W),
    .ALUResult_W(ALUResult_W), .RegDstAddress_W(RegDstAddress_W),
    .RegWrite_W(RegWrite_W), .MemToReg_W(MemToReg_W)
  );

  always #5 Clk = ~Clk;

  // Reference model: byte-addressed memory image
  logic [7:0] ref_mem [MEM_BYTES];

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] bs);
    int unsigned idx, b;
    logic [15:0] h;
    logic [7:0]  y;
    idx = a % MEM_BYTES;
    case (bs)
      2'b00: begin
        b = idx & ~32'd3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
      end
      2'b01: begin
        b = idx & ~32'd1;
        h = {ref_mem[b+1], ref_mem[b]};
        return {{16{h[15]}}, h};
      end
      2'b10: begin
        y = ref_mem[idx];
        return {{24{y[7]}}, y};
      end
      default: begin
        y = ref_mem[idx];
        return {24'h0, y};
      end
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] bs);
    int unsigned idx;
    idx = a % MEM_BYTES;
    case (bs)
      2'b00:   for (int i = 0; i < 4; i++) ref_mem[(idx & ~32'd3) + i] = d[8*i +: 8];
      2'b01:   for (int i = 0; i < 2; i++) ref_mem[(idx & ~32'd1) + i] = d[8*i +: 8];
      default: ref_mem[idx] = d[7:0];
    endcase
  endtask

  function automatic logic ref_cond(input logic [2:0] op, input logic z, input logic s);
    case (op)
      3'd0:    return z;
      3'd1:    return !z;
      3'd2:    return !s;
      3'd3:    return !s && !z;
      3'd4:    return s || z;
      3'd5:    return s;
      default: return 1'b0;
    endcase
  endfunction

  // Stimulus helpers
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_nop();
    Reset = 1'b0; Flush = 1'b0;
    ALUResult = '0; WriteData = '0; AddResult = '0; Zero = 1'b0; SignBit = 1'b0;
    RegDstAddress = '0; Branch = 1'b0; RegWrite = 1'b0; MemWrite = 1'b0;
    MemRead = 1'b0; MemToReg = 1'b0; BitSel = 2'b00; BranchLogicOp = 3'b000;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] bs);
    drive_nop();
    ALUResult = a; WriteData = d; BitSel = bs; MemWrite = 1'b1;
  endtask

  task automatic drive_load(input logic [31:0] a, input logic [1:0] bs);
    drive_nop();
    ALUResult = a; BitSel = bs; MemRead = 1'b1; RegWrite = 1'b1; MemToReg = 1'b1;
  endtask

  task automatic do_reset();
    drive_nop();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
  endtask

  // Store then drain so the write has landed
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] bs);
    drive_store(a, d, bs); step();
    drive_nop();           step();
  endtask

  // Load; returns with the result in MemReadData_W
  task automatic load(input logic [31:0] a, input logic [1:0] bs);
    drive_load(a, bs); step();
    drive_nop();       step();
  endtask

  task automatic test_reset();
    drive_nop();
    Reset = 1'b1; Flush = 1'b1; Branch = 1'b1; RegWrite = 1'b1; MemRead = 1'b1;
    MemWrite = 1'b1; MemToReg = 1'b1; ALUResult = $urandom; AddResult = $urandom;
    Zero = 1'b1; RegDstAddress = 5'd17;
    step();
    step();
    total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL reset_pcsrc got=%b exp=0", PCSrc); end
    total++; if (BranchTarget !== 32'h0) begin bad++; $display("FAIL reset_target got=%h exp=0", BranchTarget); end
    total++; if (MemReadData_W !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", MemReadData_W); end
    total++; if (ALUResult_W !== 32'h0) begin bad++; $display("FAIL reset_alu_w got=%h exp=0", ALUResult_W); end
    total++; if (RegDstAddress_W !== 5'h0) begin bad++; $display("FAIL reset_dst_w got=%h exp=0", RegDstAddress_W); end
    total++; if ({RegWrite_W, MemToReg_W} !== 2'b00) begin bad++; $display("FAIL reset_ctrl_w got=%b exp=00", {RegWrite_W, MemToReg_W}); end
    do_reset();
    load(32'h0000_0084, 2'b00);
    total++; if (MemReadData_W !== 32'h0) begin bad++; $display("FAIL reset_mem got=%h exp=0", MemReadData_W); end
  endtask

  task automatic test_word();
    do_reset();
    drive_store(32'h10, 32'hDEADBEEF, 2'b00); step();
    drive_load(32'h10, 2'b00);                step();
    drive_nop();                              step();
    total++; if (MemReadData_W !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_lw got=%h exp=deadbeef", MemReadData_W); end
    total++; if (ALUResult_W !== 32'h10) begin bad++; $display("FAIL sw_lw_alu got=%h exp=10", ALUResult_W); end
  endtask

  task automatic test_byte();
    do_reset();
    store(32'h21, 32'h0000_0080, 2'b10);
    load(32'h21, 2'b10);
    total++; if (MemReadData_W !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h exp=ffffff80", MemReadData_W); end
    load(32'h21, 2'b11);
    total++; if (MemReadData_W !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp=00000080", MemReadData_W); end
    load(32'h20, 2'b00);
    total++; if (MemReadData_W !== 32'h00008000) begin bad++; $display("FAIL lb_word got=%h exp=00008000", MemReadData_W); end
  endtask

  task automatic test_half();
    do_reset();
    store(32'h42, 32'h0000_1234, 2'b01);
    load(32'h40, 2'b00);
    total++; if (MemReadData_W !== 32'h12340000) begin bad++; $display("FAIL sh_word got=%h exp=12340000", MemReadData_W); end
    load(32'h43, 2'b01);
    total++; if (MemReadData_W !== 32'h00001234) begin bad++; $display("FAIL lh got=%h exp=00001234", MemReadData_W); end
  endtask

  task automatic test_branch();
    drive_nop();
    Branch = 1'b1; AddResult = 32'h40; BranchLogicOp = 3'b000; Zero = 1'b1;
    step();
    total++; if (PCSrc !== 1'b1) begin bad++; $display("FAIL br_eq got=%b exp=1", PCSrc); end
    total++; if (BranchTarget !== 32'h40) begin bad++; $display("FAIL br_target got=%h exp=40", BranchTarget); end
    BranchLogicOp = 3'b011; SignBit = 1'b0; Zero = 1'b1;
    step();
    total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL br_gt got=%b exp=0", PCSrc); end
    BranchLogicOp = 3'b000; Zero = 1'b1; Flush = 1'b1;
    step();
    total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL br_flush got=%b exp=0", PCSrc); end
    drive_nop();
    step();
  endtask

  task automatic test_rmw_wrap();
    do_reset();
    store(32'h8, 32'h11111111, 2'b00);
    drive_store(32'h8, 32'h22222222, 2'b00); MemRead = 1'b1; step();
    drive_nop();                                             step();
    total++; if (MemReadData_W !== 32'h11111111) begin bad++; $display("FAIL rw_old got=%h exp=11111111", MemReadData_W); end
    load(32'h8, 2'b00);
    total++; if (MemReadData_W !== 32'h22222222) begin bad++; $display("FAIL rw_new got=%h exp=22222222", MemReadData_W); end
    store(32'hFFFF_F410, 32'hCAFEF00D, 2'b00);
    load(32'h10, 2'b00);
    total++; if (MemReadData_W !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap got=%h exp=cafef00d", MemReadData_W); end
  endtask

  task automatic test_reset_store();
    do_reset();
    store(32'h30, 32'h0000_0077, 2'b00);
    drive_store(32'h30, 32'h0000_0055, 2'b00); step();
    drive_nop(); Reset = 1'b1; Flush = 1'b1; step();
    Reset = 1'b0; Flush = 1'b0;
    total++; if (MemReadData_W !== 32'h0) begin bad++; $display("FAIL rst_st_rdata got=%h exp=0", MemReadData_W); end
    total++; if (ALUResult_W !== 32'h0) begin bad++; $display("FAIL rst_st_alu got=%h exp=0", ALUResult_W); end
    total++; if ({RegWrite_W, MemToReg_W, RegDstAddress_W} !== 7'h0) begin bad++; $display("FAIL rst_st_ctrl got=%h exp=0", {RegWrite_W, MemToReg_W, RegDstAddress_W}); end
    load(32'h30, 2'b00);
    total++; if (MemReadData_W !== 32'h0) begin bad++; $display("FAIL rst_st_mem got=%h exp=0", MemReadData_W); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e_rd [N_RAND];
    logic [31:0] e_alu [N_RAND];
    logic [31:0] e_bt [N_RAND];
    logic [4:0]  e_dst [N_RAND];
    logic        e_rw [N_RAND];
    logic        e_m2r [N_RAND];
    logic        e_pc [N_RAND];
    logic        e_fl [N_RAND];
    do_reset();
    for (int k = 0; k < N_RAND + 2; k++) begin
      if (k >= 1) begin
        total++; if (PCSrc !== e_pc[k-1]) begin bad++; $display("FAIL b2b_pcsrc op=%0d got=%b exp=%b", k-1, PCSrc, e_pc[k-1]); end
        if (!e_fl[k-1]) begin
          total++; if (BranchTarget !== e_bt[k-1]) begin bad++; $display("FAIL b2b_target op=%0d got=%h exp=%h", k-1, BranchTarget, e_bt[k-1]); end
        end
      end
      if (k >= 2) begin
        total++; if (MemReadData_W !== e_rd[k-2]) begin bad++; $display("FAIL b2b_rdata op=%0d got=%h exp=%h", k-2, MemReadData_W, e_rd[k-2]); end
        total++; if ({RegWrite_W, MemToReg_W} !== {e_rw[k-2], e_m2r[k-2]}) begin bad++; $display("FAIL b2b_ctrl op=%0d got=%b exp=%b", k-2, {RegWrite_W, MemToReg_W}, {e_rw[k-2], e_m2r[k-2]}); end
        if (!e_fl[k-2]) begin
          total++; if (ALUResult_W !== e_alu[k-2]) begin bad++; $display("FAIL b2b_alu op=%0d got=%h exp=%h", k-2, ALUResult_W, e_alu[k-2]); end
          total++; if (RegDstAddress_W !== e_dst[k-2]) begin bad++; $display("FAIL b2b_dst op=%0d got=%h exp=%h", k-2, RegDstAddress_W, e_dst[k-2]); end
        end
      end
      if (k < N_RAND) begin
        drive_nop();
        Flush = ($urandom_range(0, 7) == 0);
        MemRead = $urandom_range(0, 1);
        MemWrite = ($urandom_range(0, 2) == 0);
        RegWrite = $urandom_range(0, 1);
        MemToReg = $urandom_range(0, 1);
        Branch = $urandom_range(0, 1);
        BitSel = $urandom_range(0, 3);
        BranchLogicOp = $urandom_range(0, 7);
        Zero = $urandom_range(0, 1);
        SignBit = $urandom_range(0, 1);
        RegDstAddress = $urandom_range(0, 31);
        WriteData = $urandom;
        AddResult = $urandom;
        ALUResult = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 63);
        e_alu[k] = ALUResult; e_dst[k] = RegDstAddress; e_bt[k] = AddResult; e_fl[k] = Flush;
        if (Flush) begin
          e_rd[k] = 32'h0; e_rw[k] = 1'b0; e_m2r[k] = 1'b0; e_pc[k] = 1'b0;
        end else begin
          e_rd[k] = MemRead ? ref_load(ALUResult, BitSel) : 32'h0;
          if (MemWrite) ref_store(ALUResult, WriteData, BitSel);
          e_rw[k] = RegWrite; e_m2r[k] = MemToReg;
          e_pc[k] = Branch && ref_cond(BranchLogicOp, Zero, SignBit);
        end
      end else begin
        drive_nop();
      end
      step();
    end
  endtask

  initial begin
    drive_nop();
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_branch();
    test_rmw_wrap();
    test_reset_store();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
